// File: rtl/uart_pkg.sv
// uart_pkg: constants and feeder state encoding shared by the UART transmit and receive buffers
package uart_pkg;
   localparam int UART_DATA_W      = 9;
   localparam int UART_FIFO_DEPTH  = 16;
   localparam int UART_ACK_TIMEOUT = 64;
   typedef enum logic [1:0] {FD_IDLE, FD_LAUNCH, FD_WAIT_BUSY, FD_WAIT_DONE} feeder_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO; head word is always visible on rd_data with no read latency
module uart_sync_fifo import uart_pkg::*; #(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   // count is the only occupancy source; pointers just wrap
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rp];
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= wr_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers words and launches them one at a time into the UART transmitter,
// waiting for its busy handshake and flagging launches the transmitter never acknowledged
module uart_tx_feeder import uart_pkg::*; #(
   parameter int DATA_W      = UART_DATA_W,
   parameter int DEPTH       = UART_FIFO_DEPTH,
   parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_valid,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    wr_ready,
   output logic                    uart_start,
   output logic [DATA_W-1:0]       uart_data,
   input  logic                    uart_busy,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    fifo_empty,
   output logic                    tx_error,
   input  logic                    err_clr
);
   localparam int TW = $clog2(ACK_TIMEOUT);
   feeder_state_t state;
   logic [TW-1:0] timer;
   logic [DATA_W-1:0] head;
   logic full, start_q;
   assign wr_ready = !full;
   // reset must silence the launch pulse in the very cycle it is asserted
   assign uart_start = start_q && !rst;
   uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(wr_valid), .wr_data(wr_data), .pop(state == FD_LAUNCH),
      .rd_data(head), .count(fifo_count), .full(full), .empty(fifo_empty)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FD_IDLE;
         timer     <= '0;
         start_q   <= 1'b0;
         uart_data <= '0;
         tx_error  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (err_clr) tx_error <= 1'b0;
         case (state)
            FD_IDLE: if (!fifo_empty && !uart_busy) state <= FD_LAUNCH;
            FD_LAUNCH: begin
               uart_data <= head;
               start_q   <= 1'b1;
               timer     <= '0;
               state     <= FD_WAIT_BUSY;
            end
            FD_WAIT_BUSY:
               if (uart_busy) state <= FD_WAIT_DONE;
               else if (timer == TW'(ACK_TIMEOUT-1)) begin
                  tx_error <= 1'b1;
                  state    <= FD_IDLE;
               end else timer <= timer + 1'b1;
            FD_WAIT_DONE: if (!uart_busy) state <= FD_IDLE;
            default: state <= FD_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench with a behavioural transmitter and FIFO occupancy model
module tb_uart_tx_feeder;
   localparam int DW = 9, DEPTH = 16;
   logic clk = 0, rst = 1, wr_valid = 0, err_clr = 0, force_busy = 0, model_busy = 0;
   logic [DW-1:0] wr_data = '0;
   logic wr_ready, uart_start, fifo_empty, tx_error, uart_busy;
   logic [DW-1:0] uart_data;
   logic [4:0] fifo_count;
   int errors = 0, checks = 0, cyc = 0, n_starts = 0, start_cyc = 0, m_cnt = 0;
   logic [DW-1:0] sb [$];
   logic [DW-1:0] last_word = '0;
   bit prev_start = 0, tx_respond = 1, rnd_tx = 0;
   int tx_delay = 2, tx_len = 20;
   assign uart_busy = model_busy | force_busy;

   uart_tx_feeder dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .uart_start(uart_start), .uart_data(uart_data), .uart_busy(uart_busy),
      .fifo_count(fifo_count), .fifo_empty(fifo_empty), .tx_error(tx_error), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // monitor: words leave in acceptance order; occupancy follows accepted pushes minus launches
   initial begin
      bit acc;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (rst) begin
            sb.delete();
            m_cnt = 0;
            last_word = '0;
            prev_start = 0;
         end else begin
            acc = wr_valid && m_cnt < DEPTH;
            if (uart_start) begin
               chk("start_single_cycle", prev_start, 0);
               n_starts++;
               start_cyc = cyc;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_start: got word %0h with none queued at cycle %0d", uart_data, cyc);
               end else chk("launch_word", uart_data, sb.pop_front());
               last_word = uart_data;
            end else chk("data_stable", uart_data, last_word);
            if (acc) sb.push_back(wr_data);
            m_cnt = m_cnt + int'(acc) - int'(uart_start);
            chk("fifo_count", fifo_count, m_cnt);
            chk("fifo_empty", fifo_empty, m_cnt == 0);
            chk("wr_ready", wr_ready, m_cnt < DEPTH);
            prev_start = uart_start;
         end
      end
   end

   // transmitter model: busy rises some cycles after a start and holds for a frame
   initial forever begin
      @(negedge clk);
      if (uart_start && tx_respond) begin
         repeat (rnd_tx ? int'($urandom_range(1, 3)) : tx_delay) @(negedge clk);
         model_busy = 1;
         repeat (rnd_tx ? int'($urandom_range(1, 8)) : tx_len) @(negedge clk);
         model_busy = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run not finished at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [DW-1:0] d);
      wr_valid = 1;
      wr_data = d;
      @(negedge clk);
      wr_valid = 0;
   endtask

   task automatic wait_start(input int budget);
      int n0 = n_starts;
      for (int i = 0; i < budget && n_starts == n0; i++) @(negedge clk);
      chk("start_seen", n_starts != n0, 1);
   endtask

   task automatic drain(input int budget);
      int q = 0;
      for (int i = 0; i < budget && q < 6; i++) begin
         @(negedge clk);
         q = (sb.size() == 0 && !uart_busy) ? q + 1 : 0;
      end
      chk("drained", q, 6);
   endtask

   initial begin
      int pc, n0;
      tick(3);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_uart_start", uart_start, 0);
      chk("rst_uart_data", uart_data, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_tx_error", tx_error, 0);
      rst = 0;
      tick(2);
      pc = cyc;
      push(9'h1A5);
      wait_start(20);
      chk("start_latency", start_cyc - pc, 3);
      tick(3);
      chk("busy_up", uart_busy, 1);
      chk("held_data", uart_data, 9'h1A5);
      drain(200);
      chk("single_count_zero", fifo_count, 0);
      force_busy = 1;
      n0 = n_starts;
      for (int i = 0; i < 17; i++) begin
         push(DW'(i));
         if (i == 15) chk("full_not_ready", wr_ready, 0);
      end
      chk("full_count", fifo_count, 16);
      force_busy = 0;
      tick(1);
      push(9'h1FF);
      chk("full_push_pop_count", fifo_count, 15);
      drain(2000);
      chk("fill_launches", n_starts - n0, 16);
      force_busy = 1;
      for (int i = 0; i < 8; i++) push(DW'(9'h40 + i));
      force_busy = 0;
      tick(1);
      push(9'h0AA);
      chk("mid_push_pop_count", fifo_count, 8);
      drain(2000);
      tx_respond = 0;
      push(9'h003);
      wait_start(20);
      n0 = n_starts;
      tick(63);
      chk("err_not_yet", tx_error, 0);
      tick(1);
      chk("err_timeout", tx_error, 1);
      chk("drop_count", fifo_count, 0);
      tick(5);
      chk("no_retry", n_starts, n0);
      err_clr = 1;
      tick(1);
      err_clr = 0;
      chk("err_cleared", tx_error, 0);
      push(9'h004);
      wait_start(20);
      tick(63);
      err_clr = 1;
      tick(1);
      err_clr = 0;
      chk("err_set_wins", tx_error, 1);
      err_clr = 1;
      tick(1);
      err_clr = 0;
      tx_respond = 1;
      force_busy = 1;
      n0 = n_starts;
      push(9'h155);
      tick(10);
      chk("no_start_foreign_busy", n_starts, n0);
      pc = cyc;
      force_busy = 0;
      wait_start(10);
      chk("launch_after_busy", start_cyc - pc <= 2, 1);
      drain(200);
      tx_len = 30;
      push(9'h0F0);
      wait_start(20);
      for (int i = 0; i < 5; i++) push(DW'(9'h100 + i));
      chk("in_frame_busy", uart_busy, 1);
      chk("queued_five", fifo_count, 5);
      rst = 1;
      tick(1);
      chk("rst_mid_count", fifo_count, 0);
      chk("rst_mid_empty", fifo_empty, 1);
      chk("rst_mid_start", uart_start, 0);
      chk("rst_mid_error", tx_error, 0);
      rst = 0;
      n0 = n_starts;
      for (int i = 0; i < 100 && uart_busy; i++) tick(1);
      tick(10);
      chk("no_launch_after_reset", n_starts, n0);
      rnd_tx = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 6) push(DW'($urandom));
         else tick(1);
      end
      drain(6000);
      chk("final_empty", fifo_empty, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
